// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
//   state_t      - controller FSM states
//   START_PC     - program entry addresses indexed by prog_sel
//   start_pc_of  - lookup helper returning the entry address of a program
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Entry addresses are kept at 32 bits; the top sizes them to its PC width.
    localparam logic [31:0] START_PC [4] = '{32'd0, 32'd256, 32'd512, 32'd768};

    function automatic logic [31:0] start_pc_of(input logic [1:0] sel);
        return START_PC[sel];
    endfunction

endpackage

// File: rtl/run_ctrl_phase_timer.sv
// phase_timer: loadable down-counter shared by the RST and DRAIN phases.
//   clk, reset - clock and synchronous active-high reset (count clears to 0)
//   load       - load load_val this edge (takes priority over dec)
//   load_val   - value to load
//   dec        - decrement by one this edge; holds at zero
//   zero       - count is zero
module phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences one program execution on the single-cycle core.
//   clk, reset - clock and synchronous active-high reset
//   req        - start request level; a rising edge starts a run from IDLE or DONE
//   prog_sel   - program select, latched on the start edge
//   halt       - core end-of-program indication, honoured only in RUN
//   core_rst   - core reset (IDLE and RST)
//   core_en    - core advance enable (RUN only)
//   start_pc   - entry address of the latched program
//   busy       - high in RST, RUN and DRAIN
//   done       - run complete, held until the next start
//   timeout    - last run ended on the cycle limit rather than halt
//   cycles     - edges spent in RUN during the last or current run
//   dbg_state  - current FSM state for observation
//
// Handshake: req is a level; only its 0->1 transition, sampled on clk, counts
// as a start, and only while IDLE or DONE. done stays high until that start is
// accepted, at which point it drops on the same edge. No start is queued.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D         = 12,
    parameter int CW        = 16,
    parameter int RST_CYC   = 2,
    parameter int DRAIN_CYC = 2,
    parameter int MAX_CYC   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    prog_sel,
    input  logic          halt,
    output logic          core_rst,
    output logic          core_en,
    output logic [D-1:0]  start_pc,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output state_t        dbg_state
);

    localparam int PH_MAX = (RST_CYC > DRAIN_CYC) ? RST_CYC : DRAIN_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] RST_LOAD   = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0] DRAIN_LOAD = PH_W'(DRAIN_CYC - 1);
    localparam logic [CW-1:0]   LAST_CYC   = CW'(MAX_CYC - 1);

    state_t          state, state_nxt;
    logic            req_q;
    logic            start;
    logic [1:0]      sel_q;
    logic            ph_load;
    logic [PH_W-1:0] ph_val;
    logic            ph_dec;
    logic            ph_zero;
    logic            run_exit;

    assign start    = req & ~req_q;
    // Halt takes precedence; the limit only ends the run when halt is low.
    assign run_exit = halt || (cycles == LAST_CYC);

    phase_timer #(.W(PH_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_load   = 1'b0;
        ph_val    = RST_LOAD;
        ph_dec    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RST;
                    ph_load   = 1'b1;
                    ph_val    = RST_LOAD;
                end
            end
            ST_RST: begin
                if (ph_zero) begin
                    state_nxt = ST_RUN;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_exit) begin
                    state_nxt = ST_DRAIN;
                    ph_load   = 1'b1;
                    ph_val    = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (ph_zero) begin
                    state_nxt = ST_DONE;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            sel_q   <= 2'd0;
            cycles  <= '0;
            timeout <= 1'b0;
        end else begin
            req_q <= req;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sel_q   <= prog_sel;
                        cycles  <= '0;
                        timeout <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The exiting edge is counted too, so a timed-out run
                    // ends with cycles == MAX_CYC.
                    cycles <= cycles + CW'(1);
                    if (!halt && (cycles == LAST_CYC)) begin
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from registered state only.
    assign core_rst  = (state == ST_IDLE) || (state == ST_RST);
    assign core_en   = (state == ST_RUN);
    assign busy      = (state == ST_RST) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign start_pc  = D'(start_pc_of(sel_q));
    assign dbg_state = state;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int D       = 12;
    localparam int CW      = 16;
    localparam int MAX_CYC = 16;

    logic          clk;
    logic          reset;
    logic          req;
    logic [1:0]    prog_sel;
    logic          halt;
    logic          core_rst;
    logic          core_en;
    logic [D-1:0]  start_pc;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;
    state_t        dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // Expected cycle count of each run, pushed at launch, popped at done.
    logic [CW-1:0] exp_q[$];

    run_ctrl #(
        .D         (D),
        .CW        (CW),
        .RST_CYC   (2),
        .DRAIN_CYC (2),
        .MAX_CYC   (MAX_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .prog_sel  (prog_sel),
        .halt      (halt),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .start_pc  (start_pc),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done with a cycle budget; returns edges waited.
    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (!done && waited < budget) begin
            waited++;
            tick();
        end
    endtask

    task automatic score_done(input string tag);
        logic [CW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(cycles), 32'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int waited;

        reset    = 1'b1;
        req      = 1'b0;
        prog_sel = 2'd0;
        halt     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_state",   32'(dbg_state), 32'(ST_IDLE));
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_core_en", 32'(core_en),  32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_timeout", 32'(timeout),  32'd0);
        chk("rst_cycles",  32'(cycles),   32'd0);
        chk("rst_start_pc", 32'(start_pc), 32'd0);

        reset = 1'b0;
        tick();

        // ---- Run 1: prog 2, halt on the 10th RUN cycle ----
        req      = 1'b1;
        prog_sel = 2'd2;
        exp_q.push_back(CW'(10));
        tick();
        chk("r1_start_pc", 32'(start_pc), 32'h200);
        chk("r1_busy",     32'(busy),     32'd1);
        cnt = 0;
        while (core_rst && cnt < 10) begin
            cnt++;
            tick();
        end
        chk("r1_rst_len", 32'(cnt), 32'd2);
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (core_en) cnt++;
            if (i == 10) halt = 1'b1;
            tick();
        end
        halt = 1'b0;
        chk("r1_en_len",   32'(cnt),     32'd10);
        chk("r1_en_off",   32'(core_en), 32'd0);
        chk("r1_cycles",   32'(cycles),  32'd10);
        chk("r1_drain_busy", 32'(busy),  32'd1);
        wait_done(10, waited);
        chk("r1_drain_len", 32'(waited), 32'd2);
        chk("r1_done",     32'(done),    32'd1);
        chk("r1_timeout",  32'(timeout), 32'd0);
        chk("r1_core_rst", 32'(core_rst), 32'd0);
        score_done("r1_sb_cycles");

        // req still held high: no second run
        for (int i = 0; i < 5; i++) tick();
        chk("hold_state", 32'(dbg_state), 32'(ST_DONE));
        chk("hold_busy",  32'(busy),      32'd0);
        req = 1'b0;
        tick();

        // ---- Run 2: prog 1, timeout; req pulse and prog_sel change in RUN ----
        req      = 1'b1;
        prog_sel = 2'd1;
        exp_q.push_back(CW'(MAX_CYC));
        tick();
        tick();
        tick();
        chk("r2_in_run", 32'(core_en), 32'd1);
        cnt = 0;
        while (core_en && cnt < 40) begin
            cnt++;
            if (cnt == 3) req = 1'b0;
            if (cnt == 5) begin
                req      = 1'b1;
                prog_sel = 2'd3;
            end
            tick();
        end
        chk("r2_run_len",  32'(cnt),      32'd16);
        chk("r2_start_pc", 32'(start_pc), 32'h100);
        chk("r2_timeout_at_exit", 32'(timeout), 32'd1);
        wait_done(10, waited);
        chk("r2_drain_len", 32'(waited),  32'd2);
        chk("r2_done",     32'(done),     32'd1);
        chk("r2_timeout",  32'(timeout),  32'd1);
        score_done("r2_sb_cycles");

        // req edge in DONE restarts with prog 3
        req = 1'b0;
        tick();
        req = 1'b1;
        exp_q.push_back(CW'(MAX_CYC));
        tick();
        chk("r3_done_drop",  32'(done),     32'd0);
        chk("r3_cycles_clr", 32'(cycles),   32'd0);
        chk("r3_timeout_clr", 32'(timeout), 32'd0);
        chk("r3_start_pc",   32'(start_pc), 32'h300);

        // ---- Run 3: halt in the same cycle as the limit ----
        tick();
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) halt = 1'b1;
            tick();
        end
        halt = 1'b0;
        chk("r3_cycles",  32'(cycles),  32'd16);
        chk("r3_en_off",  32'(core_en), 32'd0);
        chk("r3_timeout_exit", 32'(timeout), 32'd0);
        wait_done(10, waited);
        chk("r3_done",    32'(done),    32'd1);
        chk("r3_timeout", 32'(timeout), 32'd0);
        score_done("r3_sb_cycles");

        // ---- Run 4: reset mid-RUN, req held through reset ----
        req = 1'b0;
        tick();
        req      = 1'b1;
        prog_sel = 2'd1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("r4_cycles5", 32'(cycles),  32'd5);
        chk("r4_in_run",  32'(core_en), 32'd1);
        reset = 1'b1;
        tick();
        chk("r4_state",    32'(dbg_state), 32'(ST_IDLE));
        chk("r4_core_rst", 32'(core_rst),  32'd1);
        chk("r4_core_en",  32'(core_en),   32'd0);
        chk("r4_cycles",   32'(cycles),    32'd0);
        chk("r4_busy",     32'(busy),      32'd0);
        chk("r4_start_pc", 32'(start_pc),  32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("r4_post_start", 32'(dbg_state), 32'(ST_RST));
        chk("r4_post_busy",  32'(busy),      32'd1);
        chk("r4_post_pc",    32'(start_pc),  32'h100);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
